// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from the pipeline stages and the stage
// register write/flush controls returned to them.
//   master : pipeline side (drives stage information, consumes controls)
//   slave  : hazard controller (consumes stage information, drives controls)
interface hazard_ctrl_if;
  // Stage information
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_useRt;
  logic       ID_branch_taken;
  logic       ID_muldiv;
  logic       EX_MemRead;
  logic [4:0] EX_rt;
  logic       MEM_access;
  logic       mem_ready;
  // Pipeline register controls
  logic       PCWrite;
  logic       IFWrite;
  logic       IFflush;
  logic       IDEXWrite;
  logic       IDEXflush;
  logic       EXMEMWrite;
  logic       EXMEMflush;
  logic       md_start;

  modport master (
    output ID_rs, ID_rt, ID_useRt, ID_branch_taken, ID_muldiv,
           EX_MemRead, EX_rt, MEM_access, mem_ready,
    input  PCWrite, IFWrite, IFflush, IDEXWrite, IDEXflush,
           EXMEMWrite, EXMEMflush, md_start
  );

  modport slave (
    input  ID_rs, ID_rt, ID_useRt, ID_branch_taken, ID_muldiv,
           EX_MemRead, EX_rt, MEM_access, mem_ready,
    output PCWrite, IFWrite, IFflush, IDEXWrite, IDEXflush,
           EXMEMWrite, EXMEMflush, md_start
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage core.
// Produces PC / IF_ID / ID_EX / EX_MEM write and flush controls for load-use
// hazards, taken branches resolved in ID, multi-cycle mul/div occupancy of EX
// and data-memory wait states.
// Optional feature macro: HZ_PERF_CNT_EN adds the stall_cnt / flush_cnt
// performance counters; without it those ports and their logic are absent.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 4,   // EX occupancy of a mul/div, 2..15
  parameter int unsigned CNT_W  = 16   // performance counter width
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  hazard_ctrl_if.slave     hz
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_MD_BUSY = 2'd2
  } state_e;

  localparam logic [3:0] MD_CNT_START = 4'(MD_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic mstall;
  logic load_use;

  assign mstall   = hz.MEM_access & ~hz.mem_ready;
  assign load_use = hz.EX_MemRead & (hz.EX_rt != 5'd0) &
                    ((hz.EX_rt == hz.ID_rs) | (hz.ID_useRt & (hz.EX_rt == hz.ID_rt)));

  // Control outputs and next state, purely combinational from state, md_cnt and inputs
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    hz.PCWrite    = 1'b0;
    hz.IFWrite    = 1'b0;
    hz.IFflush    = 1'b0;
    hz.IDEXWrite  = 1'b0;
    hz.IDEXflush  = 1'b0;
    hz.EXMEMWrite = 1'b0;
    hz.EXMEMflush = 1'b0;
    hz.md_start   = 1'b0;
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;

    unique case (state_q)
      S_INIT: begin
        hz.IFflush    = 1'b1;
        hz.IDEXWrite  = 1'b1;
        hz.IDEXflush  = 1'b1;
        hz.EXMEMWrite = 1'b1;
        hz.EXMEMflush = 1'b1;
        state_d       = S_RUN;
      end

      S_RUN: begin
        if (!mstall) begin
          if (load_use) begin
            // Hold PC/IF_ID, inject a bubble into ID_EX; branch re-evaluated next cycle.
            hz.IDEXflush  = 1'b1;
            hz.EXMEMWrite = 1'b1;
          end else if (hz.ID_branch_taken) begin
            hz.PCWrite    = 1'b1;
            hz.IFflush    = 1'b1;
            hz.IDEXWrite  = 1'b1;
            hz.EXMEMWrite = 1'b1;
          end else begin
            hz.PCWrite    = 1'b1;
            hz.IFWrite    = 1'b1;
            hz.IDEXWrite  = 1'b1;
            hz.EXMEMWrite = 1'b1;
            if (hz.ID_muldiv) begin
              hz.md_start = 1'b1;
              state_d     = S_MD_BUSY;
              md_cnt_d    = MD_CNT_START;
            end
          end
        end
      end

      S_MD_BUSY: begin
        // The occupancy count runs even through memory stalls, floored at 1.
        md_cnt_d = (md_cnt_q > 4'd1) ? md_cnt_q - 4'd1 : 4'd1;
        if (!mstall) begin
          hz.EXMEMflush = 1'b1;
          if (md_cnt_q == 4'd1) state_d = S_RUN;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  // State and mul/div occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= S_INIT;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters of front-end stall cycles and branch flush cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q != S_INIT) && !hz.PCWrite && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((state_q == S_RUN) && hz.IFflush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. Each cycle it computes the write-enable and flush controls for the PC, IF_ID, ID_EX and EX_MEM registers, covering load-use hazards, taken branches/jumps resolved in ID, multi-cycle mul/div occupancy of EX, and data-memory wait states. It is the single source of the IF_ID `IFWrite`/`IFflush` inputs.

## Interface
Parameters:
- MD_LAT, 4, cycles a mul/div occupies EX, counting the first EX cycle; legal range 2..15
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ID_rs  in  5  rs field of the instruction in ID
- ID_rt  in  5  rt field of the instruction in ID
- ID_useRt  in  1  the instruction in ID reads rt
- ID_branch_taken  in  1  taken branch/jump resolved in ID
- ID_muldiv  in  1  the instruction in ID is mul/div
- EX_MemRead  in  1  the instruction in EX is a load
- EX_rt  in  5  destination of the load in EX
- MEM_access  in  1  MEM stage issues a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC loads next PC
- IFWrite  out  1  IF_ID loads
- IFflush  out  1  IF_ID clears
- IDEXWrite  out  1  ID_EX loads
- IDEXflush  out  1  ID_EX loads a bubble
- EXMEMWrite  out  1  EX_MEM loads
- EXMEMflush  out  1  EX_MEM loads a bubble
- md_start  out  1  one-cycle start pulse to the mul/div unit
- stall_cnt  out  CNT_W  front-end stall cycles (only with HZ_PERF_CNT_EN)
- flush_cnt  out  CNT_W  branch flush cycles (only with HZ_PERF_CNT_EN)

## Operation
- States: INIT, RUN, MD_BUSY. Reset forces INIT and zeroes `md_cnt` and both perf counters.
- INIT: PCWrite=0, IFWrite=0, IFflush=1, IDEXflush=1, EXMEMflush=1, IDEXWrite=1, EXMEMWrite=1, md_start=0. Next state is RUN unconditionally.
- Memory stall: `mstall = MEM_access & ~mem_ready`. In RUN or MD_BUSY, mstall forces all Write and flush outputs and md_start to 0. The state is unchanged, except as noted for the MD_BUSY counter.
- RUN, no mstall, evaluated in priority order:
  - Load-use: `EX_MemRead & EX_rt!=0 & (EX_rt==ID_rs | ID_useRt & EX_rt==ID_rt)`. Outputs: PCWrite=0, IFWrite=0, IDEXflush=1, EXMEMWrite=1. A concurrent taken branch is ignored and re-evaluated next cycle.
  - Taken branch: PCWrite=1, IFflush=1, IDEXWrite=1, EXMEMWrite=1.
  - ID_muldiv: normal advance, md_start=1. Next state is MD_BUSY with md_cnt=MD_LAT-1.
  - Otherwise, normal advance: PCWrite=IFWrite=IDEXWrite=EXMEMWrite=1, all flushes 0.
  - A mul/div waits behind a load-use stall; it is not started in the same cycle.
- MD_BUSY, no mstall:
  - Outputs: PCWrite=IFWrite=IDEXWrite=0, EXMEMflush=1. ID_branch_taken is ignored.
  - md_cnt decrements each cycle, including mstall cycles, and saturates at 1.
  - Exit to RUN when md_cnt==1 and there is no mstall. On the exit cycle the MD_BUSY outputs still apply. The first RUN cycle is the mul/div's final EX cycle, with normal advance.
- All outputs other than the counters are combinational from state, md_cnt and inputs.

## Timing
- Load-use bubble: exactly 1 cycle.
- Branch penalty: 1 cycle, since the IF_ID content is flushed.
- Mul/div holds EX for exactly MD_LAT cycles when there is no mstall: MD_LAT-1 cycles in MD_BUSY plus 1 RUN cycle.
- md_start is asserted in the ID cycle, coincident with the edge that moves mul/div into EX.
- Reset: asserting rst mid-MD_BUSY aborts to INIT immediately; outputs take their INIT values asynchronously. The first cycle after release is INIT; RUN begins the cycle after that.
- After reset release, INIT lasts exactly 1 cycle.

## Configuration
- HZ_PERF_CNT_EN defined:
  - stall_cnt increments each cycle in RUN or MD_BUSY with PCWrite=0.
  - flush_cnt increments each cycle IFflush=1 in RUN.
  - Both saturate at all-ones and are cleared only by reset.
- HZ_PERF_CNT_EN undefined: both ports are absent and no counter logic is built.

## Test plan
- Reset then release -> 1 INIT cycle with IFflush=IDEXflush=EXMEMflush=1, PCWrite=0; RUN on the following cycle; counters 0.
- Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5, with ID_branch_taken=1 in the same cycle -> one cycle of PCWrite=IFWrite=0, IDEXflush=1, IFflush=0; next cycle with EX_MemRead=0 gives IFflush=1, PCWrite=1. A load with EX_rt=0 gives no stall.
- ID_muldiv=1, MD_LAT=4 -> md_start pulses once; MD_BUSY for 3 cycles with EXMEMflush=1, PCWrite=0; RUN on cycle 4; stall_cnt=3.
- mstall for 2 cycles mid-MD_BUSY (MD_LAT=4) -> all controls 0 during the stall; MD_BUSY exit delayed to the first non-mstall cycle with md_cnt==1.
- rst asserted during MD_BUSY -> outputs at INIT values immediately, before any clock edge; no md_start after release.
- Build without HZ_PERF_CNT_EN -> control waveforms identical to the prior scenarios.
